// File: rtl/mem_map_pkg.sv
// ---------------------------------------------------------------------------
// mem_map_pkg
// Shared memory map for the CPU data bus: region limits, region enum, host
// FSM state type and the address decode helpers.
// The decode is shared with the CPU bench, so it lives here rather than
// inside the responder.
// ---------------------------------------------------------------------------
package mem_map_pkg;

    localparam logic [11:0] RAM_END       = 12'h280;  // first address past main RAM
    localparam logic [11:0] VRAM0_BASE    = 12'hE00;
    localparam logic [11:0] VRAM0_END     = 12'hE50;
    localparam logic [11:0] VRAM1_BASE    = 12'hE80;
    localparam logic [11:0] VRAM1_END     = 12'hED0;
    localparam logic [11:0] IO_BASE       = 12'hF00;
    localparam logic [11:0] IO_END        = 12'hF80;
    localparam int          VRAM_BANK_LEN = 80;       // nibbles per display bank

    typedef enum logic [1:0] {
        REG_RAM  = 2'd0,
        REG_VRAM = 2'd1,
        REG_IO   = 2'd2,
        REG_NONE = 2'd3
    } mem_region_t;

    typedef enum logic {
        H_IDLE = 1'b0,
        H_ACK  = 1'b1
    } host_state_t;

    // Classify a 12-bit bus address. The gaps between banks decode as
    // REG_NONE, so reads there return 0 and writes are dropped.
    function automatic mem_region_t decode_region(input logic [11:0] addr);
        mem_region_t region;
        region = REG_NONE;
        if (addr < RAM_END)
            region = REG_RAM;
        else if ((addr >= VRAM0_BASE && addr < VRAM0_END) ||
                 (addr >= VRAM1_BASE && addr < VRAM1_END))
            region = REG_VRAM;
        else if (addr >= IO_BASE && addr < IO_END)
            region = REG_IO;
        return region;
    endfunction

    // Linear VRAM index: bank 0 maps to 0..79, bank 1 to 80..159.
    // Only meaningful when decode_region() returned REG_VRAM.
    function automatic logic [7:0] vram_index(input logic [11:0] addr);
        logic [7:0] offset;
        offset = {1'b0, addr[6:0]};
        return addr[7] ? (offset + 8'(VRAM_BANK_LEN)) : offset;
    endfunction

endpackage

// File: rtl/cpu_mem_responder_if.sv
// ---------------------------------------------------------------------------
// cpu_mem_responder_if
// Bundles the CPU data bus, I/O pass-through, host (savestate/debug) port and
// LCD scan port of the memory responder.
//   slave  : the responder (cpu_mem_responder)
//   master : everything around it (CPU, I/O block, host, LCD)
// ---------------------------------------------------------------------------
interface cpu_mem_responder_if;

    // CPU data bus
    logic [11:0] mem_addr;
    logic        mem_read_en;
    logic        mem_write_en;
    logic [3:0]  mem_write_data;
    logic [3:0]  mem_read_data;

    // I/O window pass-through (0xF00-0xF7F)
    logic [6:0]  io_addr;
    logic        io_read;
    logic        io_write;
    logic [3:0]  io_wdata;
    logic [3:0]  io_rdata;

    // Host port
    logic        host_req;
    logic        host_we;
    logic [11:0] host_addr;
    logic [3:0]  host_wdata;
    logic [3:0]  host_rdata;
    logic        host_ack;

    // LCD scan port
    logic [7:0]  lcd_addr;
    logic [3:0]  lcd_data;

    modport slave (
        input  mem_addr, mem_read_en, mem_write_en, mem_write_data,
        output mem_read_data,
        output io_addr, io_read, io_write, io_wdata,
        input  io_rdata,
        input  host_req, host_we, host_addr, host_wdata,
        output host_rdata, host_ack,
        input  lcd_addr,
        output lcd_data
    );

    modport master (
        output mem_addr, mem_read_en, mem_write_en, mem_write_data,
        input  mem_read_data,
        input  io_addr, io_read, io_write, io_wdata,
        output io_rdata,
        output host_req, host_we, host_addr, host_wdata,
        input  host_rdata, host_ack,
        output lcd_addr,
        input  lcd_data
    );

endinterface

// File: rtl/nibble_ram.sv
// ---------------------------------------------------------------------------
// nibble_ram
// DEPTH x 4-bit storage with one write/read port and one read-only port.
// Ports:
//   clk, reset_n        : clock, async active-low reset (read-only output reg)
//   i_we/i_addr/i_wdata : write port, written on the rising edge
//   o_rdata             : asynchronous read of i_addr (the caller registers
//                         it, so the read sees pre-write contents)
//   i_ro_addr/o_ro_data : registered read-only port, 1-cycle latency;
//                         addresses >= DEPTH return 0
// Contents are not affected by reset.
// ---------------------------------------------------------------------------
module nibble_ram #(
    parameter int DEPTH = 640,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          i_we,
    input  logic [AW-1:0] i_addr,
    input  logic [3:0]    i_wdata,
    output logic [3:0]    o_rdata,
    input  logic [AW-1:0] i_ro_addr,
    output logic [3:0]    o_ro_data
);

    // One extra bit so the bound also works when DEPTH is a power of two.
    localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

    logic [3:0] r_mem [DEPTH];
    logic [3:0] r_ro_data;
    logic       w_addr_ok;
    logic       w_ro_ok;

    assign w_addr_ok = ({1'b0, i_addr}    < DEPTH_L);
    assign w_ro_ok   = ({1'b0, i_ro_addr} < DEPTH_L);

    always_ff @(posedge clk) begin
        if (i_we && w_addr_ok)
            r_mem[i_addr] <= i_wdata;
    end

    assign o_rdata = w_addr_ok ? r_mem[i_addr] : 4'h0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_ro_data <= 4'h0;
        else
            r_ro_data <= w_ro_ok ? r_mem[i_ro_addr] : 4'h0;
    end

    assign o_ro_data = r_ro_data;

endmodule

// File: rtl/cpu_mem_responder.sv
// ---------------------------------------------------------------------------
// cpu_mem_responder
// Memory-side responder for the CPU data bus. Decodes the 12-bit address into
// main RAM, display RAM, the I/O window or unmapped space; services CPU reads
// and writes, a lower-priority host port, and an independent LCD scan port.
// Ports:
//   clk     : system clock, rising edge
//   reset_n : asynchronous active-low reset
//   bus     : cpu_mem_responder_if.slave (CPU bus, I/O, host, LCD)
// ---------------------------------------------------------------------------
module cpu_mem_responder
    import mem_map_pkg::*;
#(
    parameter int RAM_DEPTH  = 640,
    parameter int VRAM_DEPTH = 160
) (
    input  logic                 clk,
    input  logic                 reset_n,
    cpu_mem_responder_if.slave   bus
);

    localparam int RAM_AW  = $clog2(RAM_DEPTH);
    localparam int VRAM_AW = $clog2(VRAM_DEPTH);

    host_state_t   r_state;
    logic          r_host_ack;
    logic [3:0]    r_host_rdata;
    logic [3:0]    r_mem_read_data;

    logic          w_cpu_active;
    logic          w_host_go;
    logic [11:0]   w_addr;
    logic          w_we;
    logic          w_re;
    logic [3:0]    w_wdata;
    mem_region_t   w_region;
    logic [3:0]    w_rd_nibble;
    logic [3:0]    w_ram_rdata;
    logic [3:0]    w_vram_rdata;
    logic [3:0]    w_ram_ro_unused;

    // The CPU owns the shared access path whenever it strobes; the host only
    // gets a slot when the FSM is idle and the CPU is quiet.
    assign w_cpu_active = bus.mem_read_en | bus.mem_write_en;
    assign w_host_go    = (r_state == H_IDLE) & bus.host_req & ~w_cpu_active;

    assign w_addr  = w_cpu_active ? bus.mem_addr       : bus.host_addr;
    assign w_wdata = w_cpu_active ? bus.mem_write_data : bus.host_wdata;
    assign w_we    = w_cpu_active ? bus.mem_write_en   : (w_host_go & bus.host_we);
    // A simultaneous CPU read+write is treated as a write only.
    assign w_re    = w_cpu_active ? (bus.mem_read_en & ~bus.mem_write_en)
                                  : (w_host_go & ~bus.host_we);

    assign w_region = decode_region(w_addr);

    nibble_ram #(.DEPTH(RAM_DEPTH)) u_ram (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_we      (w_we && (w_region == REG_RAM)),
        .i_addr    (w_addr[RAM_AW-1:0]),
        .i_wdata   (w_wdata),
        .o_rdata   (w_ram_rdata),
        .i_ro_addr ('0),
        .o_ro_data (w_ram_ro_unused)
    );

    nibble_ram #(.DEPTH(VRAM_DEPTH)) u_vram (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_we      (w_we && (w_region == REG_VRAM)),
        .i_addr    (VRAM_AW'(vram_index(w_addr))),
        .i_wdata   (w_wdata),
        .o_rdata   (w_vram_rdata),
        .i_ro_addr (VRAM_AW'(bus.lcd_addr)),
        .o_ro_data (bus.lcd_data)
    );

    always_comb begin
        w_rd_nibble = 4'h0;
        case (w_region)
            REG_RAM:  w_rd_nibble = w_ram_rdata;
            REG_VRAM: w_rd_nibble = w_vram_rdata;
            REG_IO:   w_rd_nibble = bus.io_rdata;
            default:  w_rd_nibble = 4'h0;
        endcase
    end

    // I/O strobes follow the active requester, gated by the IO decode.
    assign bus.io_addr  = w_addr[6:0];
    assign bus.io_wdata = w_wdata;
    assign bus.io_read  = w_re & (w_region == REG_IO);
    assign bus.io_write = w_we & (w_region == REG_IO);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_mem_read_data <= 4'h0;
        else if (bus.mem_read_en && !bus.mem_write_en)
            r_mem_read_data <= w_rd_nibble;
    end

    // Host FSM: accept in H_IDLE, pulse ack from H_ACK. host_req is not looked
    // at in H_ACK, which gives the host one cycle to drop it after the ack.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= H_IDLE;
            r_host_ack   <= 1'b0;
            r_host_rdata <= 4'h0;
        end else begin
            case (r_state)
                H_IDLE: begin
                    r_host_ack <= 1'b0;
                    if (w_host_go) begin
                        r_state    <= H_ACK;
                        r_host_ack <= 1'b1;
                        if (!bus.host_we)
                            r_host_rdata <= w_rd_nibble;
                    end
                end
                H_ACK: begin
                    r_host_ack <= 1'b0;
                    r_state    <= H_IDLE;
                end
                default: begin
                    r_host_ack <= 1'b0;
                    r_state    <= H_IDLE;
                end
            endcase
        end
    end

    assign bus.mem_read_data = r_mem_read_data;
    assign bus.host_ack      = r_host_ack;
    assign bus.host_rdata    = r_host_rdata;

endmodule

// File: tb/tb_cpu_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_cpu_mem_responder
// Directed scenarios for cpu_mem_responder. Inputs change 1 time unit after
// the rising edge; outputs are sampled at that same point.
// ---------------------------------------------------------------------------
module tb_cpu_mem_responder;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    cpu_mem_responder_if bus ();

    cpu_mem_responder dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.mem_addr       = 12'h000;
        bus.mem_read_en    = 1'b0;
        bus.mem_write_en   = 1'b0;
        bus.mem_write_data = 4'h0;
        bus.io_rdata       = 4'h0;
        bus.host_req       = 1'b0;
        bus.host_we        = 1'b0;
        bus.host_addr      = 12'h000;
        bus.host_wdata     = 4'h0;
        bus.lcd_addr       = 8'd200;
    endtask

    task automatic cpu_write(input logic [11:0] a, input logic [3:0] d);
        bus.mem_addr = a; bus.mem_write_data = d;
        bus.mem_write_en = 1'b1; bus.mem_read_en = 1'b0;
        step();
        bus.mem_write_en = 1'b0;
        $display("cpu write addr=%h data=%h", a, d);
    endtask

    task automatic cpu_read(input logic [11:0] a);
        bus.mem_addr = a; bus.mem_read_en = 1'b1;
        step();
        bus.mem_read_en = 1'b0;
        $display("cpu read addr=%h data=%h", a, bus.mem_read_data);
    endtask

    task automatic test_reset();
        idle_inputs();
        reset_n = 1'b0;
        step(); step();
        total++; if (bus.mem_read_data !== 4'h0) begin bad++; $display("FAIL reset_mem_read_data: got %h want 0", bus.mem_read_data); end
        total++; if (bus.host_rdata !== 4'h0) begin bad++; $display("FAIL reset_host_rdata: got %h want 0", bus.host_rdata); end
        total++; if (bus.host_ack !== 1'b0) begin bad++; $display("FAIL reset_host_ack: got %b want 0", bus.host_ack); end
        total++; if (bus.lcd_data !== 4'h0) begin bad++; $display("FAIL reset_lcd_data: got %h want 0", bus.lcd_data); end
        total++; if ({bus.io_read, bus.io_write} !== 2'b00) begin bad++; $display("FAIL reset_io_strobes: got %b want 00", {bus.io_read, bus.io_write}); end
        reset_n = 1'b1;
        step();
        $display("reset released");
    endtask

    task automatic test_cpu_rw();
        cpu_write(12'h010, 4'hB);
        cpu_read(12'h010);
        total++; if (bus.mem_read_data !== 4'hB) begin bad++; $display("FAIL cpu_read_010: got %h want b", bus.mem_read_data); end
        step();
        total++; if (bus.mem_read_data !== 4'hB) begin bad++; $display("FAIL read_hold: got %h want b", bus.mem_read_data); end
        // Both strobes: write lands, read data untouched.
        bus.mem_addr = 12'h011; bus.mem_write_data = 4'h5;
        bus.mem_read_en = 1'b1; bus.mem_write_en = 1'b1;
        step();
        bus.mem_read_en = 1'b0; bus.mem_write_en = 1'b0;
        $display("cpu read+write addr=011 data=5");
        total++; if (bus.mem_read_data !== 4'hB) begin bad++; $display("FAIL both_strobes_hold: got %h want b", bus.mem_read_data); end
        cpu_read(12'h011);
        total++; if (bus.mem_read_data !== 4'h5) begin bad++; $display("FAIL both_strobes_write: got %h want 5", bus.mem_read_data); end
    endtask

    task automatic test_vram_lcd();
        cpu_write(12'hE81, 4'h7);
        bus.lcd_addr = 8'd81;
        step();
        $display("lcd addr=81 data=%h", bus.lcd_data);
        total++; if (bus.lcd_data !== 4'h7) begin bad++; $display("FAIL lcd_81: got %h want 7", bus.lcd_data); end
        cpu_read(12'hE81);
        total++; if (bus.mem_read_data !== 4'h7) begin bad++; $display("FAIL cpu_read_E81: got %h want 7", bus.mem_read_data); end
        cpu_read(12'h300);
        total++; if (bus.mem_read_data !== 4'h0) begin bad++; $display("FAIL unmapped_300: got %h want 0", bus.mem_read_data); end
        // Bank 0 last entry
        cpu_write(12'hE4F, 4'h3);
        bus.lcd_addr = 8'd79;
        step();
        $display("lcd addr=79 data=%h", bus.lcd_data);
        total++; if (bus.lcd_data !== 4'h3) begin bad++; $display("FAIL lcd_79: got %h want 3", bus.lcd_data); end
        // Write to the gap just past bank 0 must not land in VRAM index 80.
        cpu_write(12'hE80, 4'h2);
        cpu_write(12'hE50, 4'hF);
        cpu_read(12'hE80);
        total++; if (bus.mem_read_data !== 4'h2) begin bad++; $display("FAIL unmapped_write_dropped: got %h want 2", bus.mem_read_data); end
        // LCD reads old data while CPU writes the same nibble.
        bus.lcd_addr = 8'd81;
        cpu_write(12'hE81, 4'hA);
        total++; if (bus.lcd_data !== 4'h7) begin bad++; $display("FAIL lcd_old_data: got %h want 7", bus.lcd_data); end
        step();
        $display("lcd addr=81 data=%h", bus.lcd_data);
        total++; if (bus.lcd_data !== 4'hA) begin bad++; $display("FAIL lcd_new_data: got %h want a", bus.lcd_data); end
        bus.lcd_addr = 8'd200;
        step();
        $display("lcd addr=200 data=%h", bus.lcd_data);
        total++; if (bus.lcd_data !== 4'h0) begin bad++; $display("FAIL lcd_out_of_range: got %h want 0", bus.lcd_data); end
    endtask

    task automatic test_host_vs_cpu();
        // Same cycle: CPU read of 0x011 and host read of 0x010.
        bus.mem_addr = 12'h011; bus.mem_read_en = 1'b1;
        bus.host_req = 1'b1; bus.host_we = 1'b0; bus.host_addr = 12'h010;
        step();
        bus.mem_read_en = 1'b0;
        $display("cpu read addr=011 data=%h host_ack=%b", bus.mem_read_data, bus.host_ack);
        total++; if (bus.mem_read_data !== 4'h5) begin bad++; $display("FAIL cpu_first_data: got %h want 5", bus.mem_read_data); end
        total++; if (bus.host_ack !== 1'b0) begin bad++; $display("FAIL host_waits: got %b want 0", bus.host_ack); end
        step();
        $display("host read addr=010 ack=%b data=%h", bus.host_ack, bus.host_rdata);
        total++; if (bus.host_ack !== 1'b1) begin bad++; $display("FAIL host_ack_after_cpu: got %b want 1", bus.host_ack); end
        total++; if (bus.host_rdata !== 4'hB) begin bad++; $display("FAIL host_rdata_010: got %h want b", bus.host_rdata); end
        bus.host_req = 1'b0;
        step();
        total++; if (bus.host_ack !== 1'b0) begin bad++; $display("FAIL host_ack_pulse: got %b want 0", bus.host_ack); end
    endtask

    task automatic test_host_write();
        int acks = 0;
        int first = -1;
        bus.host_req = 1'b1; bus.host_we = 1'b1;
        bus.host_addr = 12'h27F; bus.host_wdata = 4'hC;
        for (int i = 0; i < 8; i++) begin
            step();
            if (bus.host_ack === 1'b1) begin
                acks++;
                if (first < 0) first = i;
                bus.host_req = 1'b0;
            end
        end
        $display("host write addr=27f data=c acks=%0d first=%0d", acks, first);
        total++; if (acks !== 1) begin bad++; $display("FAIL host_single_ack: got %0d want 1", acks); end
        total++; if (first !== 0) begin bad++; $display("FAIL host_ack_latency: got %0d want 0", first); end
        total++; if (bus.host_rdata !== 4'hB) begin bad++; $display("FAIL host_rdata_kept_on_write: got %h want b", bus.host_rdata); end
        cpu_read(12'h27F);
        total++; if (bus.mem_read_data !== 4'hC) begin bad++; $display("FAIL cpu_read_27F: got %h want c", bus.mem_read_data); end
    endtask

    task automatic test_io();
        bus.mem_addr = 12'hF12; bus.mem_read_en = 1'b1; bus.io_rdata = 4'h9;
        #1;
        total++; if ({bus.io_read, bus.io_write} !== 2'b10) begin bad++; $display("FAIL io_read_strobe: got %b want 10", {bus.io_read, bus.io_write}); end
        total++; if (bus.io_addr !== 7'h12) begin bad++; $display("FAIL io_addr_12: got %h want 12", bus.io_addr); end
        step();
        bus.mem_read_en = 1'b0; bus.io_rdata = 4'h0;
        $display("io read addr=f12 data=%h", bus.mem_read_data);
        total++; if (bus.mem_read_data !== 4'h9) begin bad++; $display("FAIL io_read_data: got %h want 9", bus.mem_read_data); end
        bus.mem_addr = 12'hF05; bus.mem_write_en = 1'b1; bus.mem_write_data = 4'h3;
        #1;
        total++; if ({bus.io_read, bus.io_write} !== 2'b01) begin bad++; $display("FAIL io_write_strobe: got %b want 01", {bus.io_read, bus.io_write}); end
        total++; if ({bus.io_addr, bus.io_wdata} !== {7'h05, 4'h3}) begin bad++; $display("FAIL io_write_bus: got %h/%h want 05/3", bus.io_addr, bus.io_wdata); end
        step();
        bus.mem_write_en = 1'b0;
        $display("io write addr=f05 data=3");
        bus.mem_addr = 12'hF80; bus.mem_read_en = 1'b1;
        #1;
        total++; if (bus.io_read !== 1'b0) begin bad++; $display("FAIL io_gap_no_strobe: got %b want 0", bus.io_read); end
        step();
        bus.mem_read_en = 1'b0;
        $display("cpu read addr=f80 data=%h", bus.mem_read_data);
    endtask

    task automatic test_reset_mid();
        bus.host_req = 1'b1; bus.host_we = 1'b0; bus.host_addr = 12'h27F;
        step();
        $display("host read addr=27f ack=%b data=%h", bus.host_ack, bus.host_rdata);
        total++; if (bus.host_ack !== 1'b1) begin bad++; $display("FAIL pre_reset_ack: got %b want 1", bus.host_ack); end
        total++; if (bus.host_rdata !== 4'hC) begin bad++; $display("FAIL pre_reset_rdata: got %h want c", bus.host_rdata); end
        reset_n = 1'b0;
        #1;
        $display("reset asserted in H_ACK ack=%b", bus.host_ack);
        total++; if (bus.host_ack !== 1'b0) begin bad++; $display("FAIL reset_drops_ack: got %b want 0", bus.host_ack); end
        total++; if (bus.host_rdata !== 4'h0) begin bad++; $display("FAIL reset_clears_rdata: got %h want 0", bus.host_rdata); end
        step();
        reset_n = 1'b1;
        step();
        $display("host re-serviced ack=%b data=%h", bus.host_ack, bus.host_rdata);
        total++; if (bus.host_ack !== 1'b1) begin bad++; $display("FAIL reservice_ack: got %b want 1", bus.host_ack); end
        total++; if (bus.host_rdata !== 4'hC) begin bad++; $display("FAIL reservice_rdata: got %h want c", bus.host_rdata); end
        bus.host_req = 1'b0;
        step();
        total++; if (bus.host_ack !== 1'b0) begin bad++; $display("FAIL reservice_pulse: got %b want 0", bus.host_ack); end
    endtask

    initial begin
        test_reset();
        test_cpu_rw();
        test_vram_lcd();
        test_host_vs_cpu();
        test_host_write();
        test_io();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
